// File: rtl/neuron_mac.sv
// Single neuron multiply-accumulate: weight memory, 3-stage MAC pipeline and bias add.
// Define ACC_SATURATE_EN to saturate the accumulate and bias additions instead of wrapping.
module neuron_mac #(
    parameter int dataWidth    = 16,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            weightValid,
    input  logic [addressWidth-1:0]         weightAddr,
    input  logic signed [dataWidth-1:0]     weightValue,
    input  logic                            biasValid,
    input  logic signed [2*dataWidth-1:0]   biasValue,
    input  logic                            myinputValid,
    input  logic signed [dataWidth-1:0]     myinput,
    output logic signed [2*dataWidth-1:0]   out,
    output logic                            outvalid
);
    localparam int accWidth = 2*dataWidth;
    localparam int idxWidth = (numWeight > 1) ? $clog2(numWeight) : 1;
    localparam logic [addressWidth:0]   numWeightL = (addressWidth+1)'(numWeight);
    localparam logic [addressWidth-1:0] lastAddr   = addressWidth'(numWeight-1);

    logic signed [dataWidth-1:0] weightMem [numWeight];
    logic signed [accWidth-1:0]  bias;

    logic [addressWidth-1:0]     rdCnt;
    logic                        v0, v1, v2;
    logic                        last0, last1, last2;
    logic signed [dataWidth-1:0] x0, x1, w1;
    logic [idxWidth-1:0]         a0;
    logic signed [accWidth-1:0]  p2;
    logic signed [accWidth-1:0]  acc;

    function automatic logic signed [accWidth-1:0] addAcc(
        input logic signed [accWidth-1:0] a,
        input logic signed [accWidth-1:0] b
    );
        logic signed [accWidth-1:0] s;
        s = a + b;
`ifdef ACC_SATURATE_EN
        // Overflow only when both operands share a sign the result does not.
        if ((a[accWidth-1] == b[accWidth-1]) && (s[accWidth-1] != a[accWidth-1]))
            s = a[accWidth-1] ? {1'b1, {(accWidth-1){1'b0}}} : {1'b0, {(accWidth-1){1'b1}}};
`endif
        return s;
    endfunction

    // Memory and bias are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (weightValid && ({1'b0, weightAddr} < numWeightL))
            weightMem[weightAddr[idxWidth-1:0]] <= weightValue;
        if (biasValid)
            bias <= biasValue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdCnt    <= '0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            last0    <= 1'b0;
            last1    <= 1'b0;
            last2    <= 1'b0;
            acc      <= '0;
            out      <= '0;
            outvalid <= 1'b0;
        end else begin
            v0    <= myinputValid;
            last0 <= (rdCnt == lastAddr);
            x0    <= myinput;
            a0    <= rdCnt[idxWidth-1:0];
            if (myinputValid)
                rdCnt <= (rdCnt == lastAddr) ? '0 : rdCnt + 1'b1;

            v1    <= v0;
            last1 <= last0;
            x1    <= x0;
            w1    <= weightMem[a0];

            v2    <= v1;
            last2 <= last1;
            p2    <= accWidth'(x1) * accWidth'(w1);

            outvalid <= 1'b0;
            if (v2) begin
                if (last2) begin
                    out      <= addAcc(addAcc(acc, p2), bias);
                    outvalid <= 1'b1;
                    acc      <= '0;
                end else begin
                    acc <= addAcc(acc, p2);
                end
            end
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac with numWeight=4; honours ACC_SATURATE_EN when defined.
module tb_neuron_mac;
    localparam int DW  = 16;
    localparam int NW  = 4;
    localparam int ADW = 3;

    logic                   clk;
    logic                   rst;
    logic                   weightValid;
    logic [ADW-1:0]         weightAddr;
    logic signed [DW-1:0]   weightValue;
    logic                   biasValid;
    logic signed [2*DW-1:0] biasValue;
    logic                   myinputValid;
    logic signed [DW-1:0]   myinput;
    logic signed [2*DW-1:0] out;
    logic                   outvalid;

    neuron_mac #(.dataWidth(DW), .numWeight(NW), .addressWidth(ADW)) dut (
        .clk(clk), .rst(rst),
        .weightValid(weightValid), .weightAddr(weightAddr), .weightValue(weightValue),
        .biasValid(biasValid), .biasValue(biasValue),
        .myinputValid(myinputValid), .myinput(myinput),
        .out(out), .outvalid(outvalid)
    );

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        ent;
    int          wt[NW];
    longint      bias_m;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_out = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic longint norm(input longint v);
        longint r;
`ifdef ACC_SATURATE_EN
        r = v;
        if (v > 64'sh7FFF_FFFF) r = 64'sh7FFF_FFFF;
        if (v < -64'sh8000_0000) r = -64'sh8000_0000;
`else
        r = {{32{v[31]}}, v[31:0]};
`endif
        return r;
    endfunction

    function automatic logic [31:0] model(input int xs[NW]);
        longint a;
        a = 0;
        for (int i = 0; i < NW - 1; i++)
            a = norm(a + longint'(xs[i]) * longint'(wt[i]));
        a = norm(a + longint'(xs[NW-1]) * longint'(wt[NW-1]));
        a = norm(a + bias_m);
        return a[31:0];
    endfunction

    always @(posedge clk) begin
        #1;
        if (outvalid === 1'b1) begin
            if (sbq.size() == 0) begin
                check_val("spurious_outvalid", 32'd1, 32'd0);
            end else begin
                ent = sbq.pop_front();
                check_val("out", out, ent.val);
                check_val("latency", cyc, ent.cyc);
                last_out = ent.val;
            end
        end
    end

    task automatic drive(input bit v, input int x);
        @(negedge clk);
        myinputValid = v;
        myinput      = DW'(x);
    endtask

    task automatic set_w(input int a, input int v);
        @(negedge clk);
        myinputValid = 1'b0;
        weightValid  = 1'b1;
        weightAddr   = ADW'(a);
        weightValue  = DW'(v);
        @(negedge clk);
        weightValid  = 1'b0;
        if (a < NW) wt[a] = v;
    endtask

    task automatic set_bias(input longint b);
        @(negedge clk);
        myinputValid = 1'b0;
        biasValid    = 1'b1;
        biasValue    = b[31:0];
        @(negedge clk);
        biasValid    = 1'b0;
        bias_m       = b;
    endtask

    task automatic run_vec(input int xs[NW], input int gaps[NW-1]);
        for (int i = 0; i < NW; i++) begin
            drive(1'b1, xs[i]);
            if (i == NW - 1) begin
                ent.val = model(xs);
                ent.cyc = cyc + 4;
                sbq.push_back(ent);
            end else begin
                for (int g = 0; g < gaps[i]; g++) drive(1'b0, 0);
            end
        end
    endtask

    task automatic drain();
        drive(1'b0, 0);
        for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge clk);
        if (sbq.size() != 0) check_val("drain_timeout", sbq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones[NW]  = '{1, 1, 1, 1};
        int vb[NW]    = '{2, 0, 0, -1};
        int vg[NW]    = '{3, -2, 5, 7};
        int v1000[NW] = '{1, 0, 0, 0};
        int vmax[NW]  = '{32767, 32767, 32767, 32767};
        int vmin[NW]  = '{-32768, -32768, -32768, -32768};
        int nog[NW-1] = '{0, 0, 0};
        int gp[NW-1]  = '{1, 2, 3};

        rst = 1'b1; weightValid = 1'b0; weightAddr = '0; weightValue = '0;
        biasValid = 1'b0; biasValue = '0; myinputValid = 1'b0; myinput = '0;
        repeat (3) @(negedge clk);
        check_val("rst_out", out, 32'd0);
        check_val("rst_outvalid", {31'd0, outvalid}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NW; i++) set_w(i, i + 1);
        set_w(4, 100);          // out of range: must not alias onto address 0
        set_bias(10);

        run_vec(ones, nog);     // 1+2+3+4+10 = 20
        drain();
        repeat (3) drive(1'b0, 0);
        check_val("hold", out, last_out);
        check_val("hold_outvalid", {31'd0, outvalid}, 32'd0);

        set_bias(0);
        run_vec(ones, nog);     // back to back: 10 then -2
        run_vec(vb, nog);
        drain();

        set_bias(10);
        run_vec(vg, gp);
        drain();

        drive(1'b1, 1);
        drive(1'b1, 1);
        @(negedge clk);
        rst = 1'b1;
        myinputValid = 1'b1;
        myinput = 16'sd5;
        @(negedge clk);
        rst = 1'b0;
        myinputValid = 1'b0;
        check_val("rst_mid_out", out, 32'd0);
        check_val("rst_mid_outvalid", {31'd0, outvalid}, 32'd0);
        run_vec(ones, nog);     // 20 again: partial sum discarded
        drain();

        run_vec(ones, nog);     // bias write on the final-accumulate edge
        drive(1'b0, 0);
        drive(1'b0, 0);
        @(negedge clk);
        biasValid = 1'b1;
        biasValue = 32'sd1000;
        @(negedge clk);
        biasValid = 1'b0;
        bias_m = 1000;
        drain();
        run_vec(v1000, nog);    // 1 + 1000
        drain();

        set_bias(0);
        for (int i = 0; i < NW - 1; i++) drive(1'b1, 1);
        @(negedge clk);         // input 3 sampled on the edge that reads weight 2
        myinputValid = 1'b1;
        myinput = 16'sd1;
        weightValid = 1'b1;
        weightAddr = 3'd2;
        weightValue = 16'sd10;
        ent.val = model(ones);  // old weight: 10
        ent.cyc = cyc + 4;
        sbq.push_back(ent);
        wt[2] = 10;
        @(negedge clk);
        weightValid = 1'b0;
        myinputValid = 1'b0;
        drain();
        run_vec(ones, nog);     // new weight: 1+2+10+4 = 17
        drain();

        for (int i = 0; i < NW; i++) set_w(i, 32767);
        set_bias(64'sh7FFF_FFFF);
        run_vec(vmax, nog);
        drain();
        set_bias(-64'sh8000_0000);
        run_vec(vmin, nog);
        drain();

        repeat (5) drive(1'b0, 0);
        check_val("queue_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 The module SHALL have parameter dataWidth, default 16, giving the signed input, weight and output-lane width.
REQ-002 The module SHALL have parameter numWeight, default 784, giving the number of inputs per neuron (range 2..4096).
REQ-003 The module SHALL have parameter addressWidth, default 10, giving the weight-address width (2**addressWidth >= numWeight).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 weightValid  input  1  write strobe for weight memory.
REQ-007 weightAddr  input  addressWidth  weight write address.
REQ-008 weightValue  input  dataWidth  signed weight write data.
REQ-009 biasValid  input  1  write strobe for bias register.
REQ-010 biasValue  input  2*dataWidth  signed bias, product-aligned.
REQ-011 myinputValid  input  1  qualifies myinput; one input per asserted cycle.
REQ-012 myinput  input  dataWidth  signed input sample.
REQ-013 out  output  2*dataWidth  signed neuron sum, consumed by the ReLU stage.
REQ-014 outvalid  output  1  one-cycle pulse qualifying out.

Function
REQ-015 Weight memory SHALL hold numWeight signed entries, written when weightValid=1 at weightAddr; addresses >= numWeight SHALL be ignored.
REQ-016 A read counter SHALL start at 0, increment on each myinputValid=1, and wrap to 0 after numWeight-1.
REQ-017 The pipeline SHALL have three stages: E0 samples input and read address; E1 registers weight read data and delayed input; E2 registers signed product input*weight (2*dataWidth bits).
REQ-018 The accumulator stage SHALL add each valid product to a 2*dataWidth signed accumulator on the edge after E2.
REQ-019 For the product of the numWeight-th input, the stage SHALL register out = (acc + product) + bias instead of updating acc, assert outvalid for exactly one cycle, and clear acc to 0 on the same edge.
REQ-020 Latency: the last input is sampled at edge E; out/outvalid SHALL update at edge E+3.
REQ-021 Back-to-back vectors SHALL be supported without bubbles: the first input of the next vector MAY be sampled at E+1.
REQ-022 Gaps (myinputValid=0) SHALL stall nothing and add nothing; valid tags propagate per stage.
REQ-023 Simultaneous weight write and read to the same address SHALL return the old weight.
REQ-024 biasValid SHALL update bias on the next edge; a bias write in the final-accumulate cycle SHALL not affect that cycle's sum.
REQ-025 out SHALL hold its value between outvalid pulses.

Reset
REQ-026 On rst=1: read counter, pipeline valid tags and acc SHALL clear to 0; out SHALL be 0; outvalid SHALL be 0.
REQ-027 Reset SHALL NOT alter weight memory or the bias register.
REQ-028 Reset mid-vector SHALL discard the partial sum; the next vector starts at weight 0.
REQ-029 Inputs sampled while rst=1 SHALL be ignored.

Configuration
REQ-030 Macro ACC_SATURATE_EN SHALL control overflow handling of the accumulate and bias additions.
REQ-031 With ACC_SATURATE_EN defined, each addition SHALL saturate on signed overflow to 0x7FFF_FFFF (positive) or 0x8000_0000 (negative), for dataWidth=16.
REQ-032 Without ACC_SATURATE_EN, each addition SHALL wrap in two's complement.

Verification
REQ-033 numWeight=4, weights {1,2,3,4}, bias 10, inputs {1,1,1,1} -> out=20, outvalid one pulse at E+3.
REQ-034 Same weights; two vectors back to back, inputs {1,1,1,1} then {2,0,0,-1}, bias 0 -> out=10 then out=-2, with no cross-contamination.
REQ-035 Inputs with myinputValid gaps of 0..3 cycles -> same sum as gapless; outvalid 3 edges after the last input.
REQ-036 rst asserted after two of four inputs, then a full vector {1,1,1,1} -> out=20 (bias 10), partial sum discarded, weights intact.
REQ-037 Weights all 0x7FFF, inputs all 0x7FFF, numWeight=4, bias 0x7FFF_FFFF -> with ACC_SATURATE_EN out=0x7FFF_FFFF; without it, the two's-complement wrapped value.
REQ-038 Weight write to address 2 in the same cycle it is read -> old weight used; new weight used on the next vector.
